// File: rtl/wb_burst_sram_if.sv
// Wishbone B4 bus bundle with registered-feedback burst tags.
// One instance per point-to-point slave link.
interface wb_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) ();
  logic [ADDR_WIDTH-1:0]   ADR;
  logic [DATA_WIDTH-1:0]   DAT_W;
  logic [DATA_WIDTH-1:0]   DAT_R;
  logic [DATA_WIDTH/8-1:0] SEL;
  logic                    CYC;
  logic                    STB;
  logic                    WE;
  logic [2:0]              CTI;
  logic [1:0]              BTE;
  logic                    ACK;
  logic                    ERR;

  modport slave (
    input  ADR, DAT_W, SEL, CYC, STB, WE, CTI, BTE,
    output DAT_R, ACK, ERR
  );

  modport master (
    output ADR, DAT_W, SEL, CYC, STB, WE, CTI, BTE,
    input  DAT_R, ACK, ERR
  );
endinterface

// File: rtl/wb_burst_sram.sv
// Single-port synchronous SRAM behind a Wishbone slave port.
// Supports classic cycles and incrementing/wrapping bursts.
module wb_burst_sram #(
  parameter int WB_ADDR_WIDTH = 32,
  parameter int WB_DATA_WIDTH = 32,
  parameter int MEM_ADDR_BITS = 10
) (
  input logic clk,
  input logic rstn,
  wb_if.slave s
);
  localparam int OB    = $clog2(WB_DATA_WIDTH / 8);
  localparam int NB    = WB_DATA_WIDTH / 8;
  localparam int DEPTH = 1 << MEM_ADDR_BITS;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] CLASSIC = 2'd1;
  localparam logic [1:0] BURST   = 2'd2;

  typedef logic [MEM_ADDR_BITS-1:0] idx_t;

  logic [1:0]               state;
  logic [1:0]               state_d;
  idx_t                     addr_q;
  idx_t                     addr_d;
  idx_t                     mem_addr;
  idx_t                     nxt;
  idx_t                     adr_idx;
  idx_t                     wrap_mask;
  logic [1:0]               bte_q;
  logic [1:0]               bte_d;
  logic                     ack_q;
  logic                     rd_en;
  logic                     wr_en;
  logic                     go;
  logic                     unused_adr;
  logic [WB_DATA_WIDTH-1:0] rdata;
  logic [WB_DATA_WIDTH-1:0] mem [DEPTH];

  assign go         = s.CYC & s.STB;
  assign adr_idx    = s.ADR[MEM_ADDR_BITS+OB-1:OB];
  assign unused_adr = ^s.ADR[WB_ADDR_WIDTH-1:0];

  assign s.ACK   = ack_q & go;
  assign s.ERR   = 1'b0;
  assign s.DAT_R = rdata;

  // Bits inside the mask count; bits outside it are frozen.
  always_comb begin
    wrap_mask = '1;
    unique case (bte_q)
      2'b01:   wrap_mask = idx_t'(3);
      2'b10:   wrap_mask = idx_t'(7);
      2'b11:   wrap_mask = idx_t'(15);
      default: wrap_mask = '1;
    endcase
  end

  assign nxt = (addr_q & ~wrap_mask)
             | ((addr_q + idx_t'(1)) & wrap_mask);

  always_comb begin
    state_d  = state;
    addr_d   = addr_q;
    bte_d    = bte_q;
    mem_addr = addr_q;
    rd_en    = 1'b0;
    wr_en    = 1'b0;
    unique case (1'b1)
      (state == IDLE): begin
        if (go) begin
          addr_d   = adr_idx;
          bte_d    = s.BTE;
          mem_addr = adr_idx;
          rd_en    = 1'b1;
          state_d  = (s.CTI == 3'b010) ? BURST : CLASSIC;
        end
      end
      (state == CLASSIC): begin
        wr_en   = go & s.WE;
        state_d = IDLE;
      end
      (state == BURST): begin
        if (!go) begin
          state_d = IDLE;
        end else begin
          // One port: a write beat skips the prefetch.
          wr_en  = s.WE;
          rd_en  = !s.WE;
          addr_d = nxt;
          if (!s.WE) mem_addr = nxt;
          if (s.CTI == 3'b111) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (!s.CYC) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state  <= IDLE;
      ack_q  <= 1'b0;
      addr_q <= '0;
      bte_q  <= 2'b00;
      rdata  <= '0;
    end else begin
      state  <= state_d;
      ack_q  <= (state_d != IDLE);
      addr_q <= addr_d;
      bte_q  <= bte_d;
      if (rd_en) rdata <= mem[mem_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < NB; i++) begin
        if (s.SEL[i]) mem[mem_addr][i*8 +: 8] <= s.DAT_W[i*8 +: 8];
      end
    end
  end
endmodule

// File: tb/tb_wb_burst_sram.sv
// Directed bench for wb_burst_sram: classic table, bursts,
// STB pause and reset abort.
module tb_wb_burst_sram;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  wb_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  wb_burst_sram #(
    .WB_ADDR_WIDTH(32),
    .WB_DATA_WIDTH(32),
    .MEM_ADDR_BITS(10)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .s   (bus.slave)
  );

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic [2:0]  cti;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [12];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic idle();
    bus.CYC   = 1'b0;
    bus.STB   = 1'b0;
    bus.WE    = 1'b0;
    bus.CTI   = 3'b000;
    bus.BTE   = 2'b00;
    bus.SEL   = 4'h0;
    bus.ADR   = 32'h0;
    bus.DAT_W = 32'h0;
  endtask

  task automatic classic(input logic we,
                         input logic [31:0] adr,
                         input logic [31:0] dat,
                         input logic [3:0] sel,
                         input logic [2:0] cti,
                         output logic [31:0] rd,
                         output int waitc);
    @(posedge clk); #1;
    bus.CYC = 1'b1; bus.STB = 1'b1; bus.WE = we;
    bus.ADR = adr; bus.DAT_W = dat; bus.SEL = sel;
    bus.CTI = cti; bus.BTE = 2'b00;
    waitc = 0;
    rd = 32'h0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.ACK) begin
        rd = bus.DAT_R;
        break;
      end
      waitc++;
    end
    @(posedge clk); #1;
    idle();
  endtask

  task automatic burst_rd(input string nm,
                          input logic [31:0] adr,
                          input logic [1:0] bte,
                          input logic [31:0] e0, e1, e2, e3);
    logic [31:0] ex [4];
    ex[0] = e0; ex[1] = e1; ex[2] = e2; ex[3] = e3;
    @(posedge clk); #1;
    bus.CYC = 1'b1; bus.STB = 1'b1; bus.WE = 1'b0;
    bus.ADR = adr; bus.CTI = 3'b010; bus.BTE = bte;
    bus.SEL = 4'hF;
    @(negedge clk);
    chk({nm, " wait"}, {31'b0, bus.ACK}, 32'h0);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
        bus.ADR = 32'hFFFF_0F00;
        bus.BTE = ~bte;
        bus.CTI = (k == 3) ? 3'b111 : 3'b010;
      end
      @(negedge clk);
      chk($sformatf("%s ack%0d", nm, k), {31'b0, bus.ACK}, 32'h1);
      chk($sformatf("%s dat%0d", nm, k), bus.DAT_R, ex[k]);
    end
    @(posedge clk); #1;
    bus.CTI = 3'b010; bus.ADR = adr;
    @(negedge clk);
    chk({nm, " end"}, {31'b0, bus.ACK}, 32'h0);
    idle();
  endtask

  function automatic logic [31:0] wd(input int k);
    return 32'hB000_0000 + 32'(k);
  endfunction

  logic [31:0] rd;
  int waitc;
  logic [3:0] seq;

  initial begin
    tbl[0]  = '{1'b1, 32'h10,   32'hDEADBEEF, 4'hF, 3'b000, 32'h0};
    tbl[1]  = '{1'b0, 32'h10,   32'h0,        4'hF, 3'b000, 32'hDEADBEEF};
    tbl[2]  = '{1'b1, 32'h20,   32'h11223344, 4'hF, 3'b001, 32'h0};
    tbl[3]  = '{1'b1, 32'h20,   32'hAABBCCDD, 4'h2, 3'b111, 32'h0};
    tbl[4]  = '{1'b0, 32'h20,   32'h0,        4'hF, 3'b011, 32'h1122CC44};
    tbl[5]  = '{1'b1, 32'h10,   32'h55555555, 4'h0, 3'b110, 32'h0};
    tbl[6]  = '{1'b0, 32'h10,   32'h0,        4'hF, 3'b111, 32'hDEADBEEF};
    tbl[7]  = '{1'b0, 32'h1010, 32'h0,        4'hF, 3'b100, 32'hDEADBEEF};
    tbl[8]  = '{1'b1, 32'h30,   32'h0,        4'hF, 3'b101, 32'h0};
    tbl[9]  = '{1'b1, 32'h30,   32'h12345678, 4'h9, 3'b000, 32'h0};
    tbl[10] = '{1'b0, 32'h30,   32'h0,        4'hF, 3'b000, 32'h12000078};
    tbl[11] = '{1'b0, 32'h20,   32'h0,        4'hF, 3'b001, 32'h1122CC44};

    idle();
    #1;
    chk("rst ack", {31'b0, bus.ACK}, 32'h0);
    chk("rst dat", bus.DAT_R, 32'h0);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;

    for (int i = 0; i < 12; i++) begin
      classic(tbl[i].we, tbl[i].adr, tbl[i].dat, tbl[i].sel,
              tbl[i].cti, rd, waitc);
      chk($sformatf("vec%0d wait", i), 32'(waitc), 32'h1);
      if (!tbl[i].we) chk($sformatf("vec%0d data", i), rd, tbl[i].exp);
    end

    // Held STB: classic accesses never ACK back-to-back.
    @(posedge clk); #1;
    bus.CYC = 1'b1; bus.STB = 1'b1; bus.ADR = 32'h10;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      seq[i] = bus.ACK;
    end
    chk("no b2b ack", {28'b0, seq}, 32'hA);
    @(posedge clk); #1;
    idle();

    for (int w = 4; w < 8; w++) begin
      classic(1'b1, 32'(w * 4), 32'(w), 4'hF, 3'b000, rd, waitc);
    end
    for (int w = 64; w < 80; w++) begin
      classic(1'b1, 32'(w * 4), 32'(w), 4'hF, 3'b000, rd, waitc);
    end

    burst_rd("lin",    32'h100, 2'b00, 32'h40, 32'h41, 32'h42, 32'h43);
    burst_rd("wrap4",  32'h018, 2'b01, 32'h06, 32'h07, 32'h04, 32'h05);
    burst_rd("wrap8",  32'h118, 2'b10, 32'h46, 32'h47, 32'h40, 32'h41);
    burst_rd("wrap16", 32'h138, 2'b11, 32'h4E, 32'h4F, 32'h40, 32'h41);

    // 8-beat linear write, STB dropped for 2 cycles after beat 2.
    @(posedge clk); #1;
    bus.CYC = 1'b1; bus.STB = 1'b1; bus.WE = 1'b1;
    bus.ADR = 32'h200; bus.CTI = 3'b010; bus.BTE = 2'b00;
    bus.SEL = 4'hF; bus.DAT_W = wd(0);
    @(negedge clk);
    chk("wb wait", {31'b0, bus.ACK}, 32'h0);
    for (int k = 0; k < 8; k++) begin
      if (k == 2) begin
        @(posedge clk); #1;
        bus.STB = 1'b0;
        @(negedge clk);
        chk("wb gap0", {31'b0, bus.ACK}, 32'h0);
        @(negedge clk);
        chk("wb gap1", {31'b0, bus.ACK}, 32'h0);
        @(posedge clk); #1;
        bus.STB = 1'b1; bus.ADR = 32'h208;
        bus.CTI = 3'b010; bus.DAT_W = wd(2);
        @(negedge clk);
        chk("wb rewait", {31'b0, bus.ACK}, 32'h0);
      end else if (k > 0) begin
        @(posedge clk); #1;
        bus.ADR = 32'hFFFF_0F00;
        bus.DAT_W = wd(k);
        bus.CTI = (k == 7) ? 3'b111 : 3'b010;
      end
      @(negedge clk);
      chk($sformatf("wb ack%0d", k), {31'b0, bus.ACK}, 32'h1);
    end
    @(posedge clk); #1;
    idle();
    for (int k = 0; k < 8; k++) begin
      classic(1'b0, 32'h200 + 32'(k * 4), 32'h0, 4'hF, 3'b000, rd, waitc);
      chk($sformatf("wb rd%0d", k), rd, wd(k));
    end

    // Reset pulse during beat 3 of a read burst.
    @(posedge clk); #1;
    bus.CYC = 1'b1; bus.STB = 1'b1; bus.WE = 1'b0;
    bus.ADR = 32'h200; bus.CTI = 3'b010; bus.BTE = 2'b00;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
      end
      @(negedge clk);
    end
    chk("rb dat2", bus.DAT_R, wd(2));
    #1 rstn = 1'b0;
    #1;
    chk("mid rst ack", {31'b0, bus.ACK}, 32'h0);
    chk("mid rst dat", bus.DAT_R, 32'h0);
    idle();
    @(posedge clk); #1;
    rstn = 1'b1;
    classic(1'b0, 32'h18, 32'h0, 4'hF, 3'b000, rd, waitc);
    chk("post rst wait", 32'(waitc), 32'h1);
    chk("post rst dat", rd, 32'h6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
